// File: rtl/cam_ram_arbiter.sv
// rtl/cam_ram_arbiter.sv - shares the data RAM between the CPU memory stage and a camera pixel FIFO
//
// The CPU owns the RAM port whenever cpu_mem_req is high and is never stalled.
// Camera pixels queue in a small FIFO and drain into the frame buffer on the
// cycles the CPU leaves the port idle.
//
// Ports:
//   clk, reset           system clock; asynchronous active-low reset
//   cpu_mem_req          CPU load/store this cycle
//   write_enable         CPU store strobe (qualified by cpu_mem_req)
//   WriteAddress         CPU word address
//   WriteData            CPU store data
//   ReadData             CPU load data (ram_q passed straight through)
//   cam_valid/cam_pixel  camera pixel strobe and 8-bit grey value
//   cam_ready            FIFO has room
//   clear_overflow       clears the sticky overflow flag
//   overflow             a pixel was dropped because the FIFO was full
//   frame_done           one-cycle pulse after the last pixel of a frame is written
//   ram_address/ram_data/ram_wren/ram_q  single-port RAM macro interface
module cam_ram_arbiter #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] FRAME_BASE   = 'h0000_1000,
    parameter int                FRAME_PIXELS = 76800,
    parameter int                FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mem_req,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] WriteAddress,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    input  logic              cam_valid,
    input  logic [7:0]        cam_pixel,
    output logic              cam_ready,
    input  logic              clear_overflow,
    output logic              overflow,
    output logic              frame_done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    input  logic [31:0]       ram_q
);

    localparam int                PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = FRAME_BASE + ADDR_W'(FRAME_PIXELS - 1);

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] pix_addr;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic pix_last;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign cam_ready = ~full;

    // Fullness is judged on the pre-edge count, so a pop in the same cycle
    // never frees a slot for a pixel arriving while full.
    assign push     = reset & cam_valid & ~full;
    assign pop      = reset & ~cpu_mem_req & ~empty;
    assign pix_last = (pix_addr == LAST_ADDR);

    assign ReadData = ram_q;

    always_comb begin
        ram_address = pix_addr;
        ram_data    = '0;
        ram_wren    = 1'b0;
        if (cpu_mem_req) begin
            ram_address = WriteAddress;
            ram_data    = WriteData;
            ram_wren    = write_enable;
        end else if (pop) begin
            ram_data = {24'b0, fifo_mem[rd_ptr]};
            ram_wren = 1'b1;
        end
    end

    // Pixel storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cam_pixel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pix_addr   <= FRAME_BASE;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                pix_addr <= pix_last ? FRAME_BASE : pix_addr + ADDR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            frame_done <= pop & pix_last;
            // A drop in the same cycle as a clear request keeps the flag set.
            if (cam_valid && full) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cam_ram_arbiter.md
# cam_ram_arbiter

Shares the single-port data RAM between the pipelined ARM core's memory stage and the camera pixel stream. The CPU always has priority and is never stalled. Camera pixels are buffered in a small FIFO and written to a frame buffer region during cycles in which the CPU does not access memory. The block sits between the core's memory port, the camera capture interface and the RAM macro.

## Interface
- ADDR_W, 32: RAM word-address width
- FRAME_BASE, 32'h0000_1000: word address of pixel 0 of the frame buffer
- FRAME_PIXELS, 76800: pixels per frame (320x240); one 32-bit word per pixel
- FIFO_DEPTH, 8: camera FIFO entries; power of two, at least 2

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- cpu_mem_req  in  1  CPU memory stage performs a load or store this cycle
- write_enable  in  1  CPU store strobe, qualified by cpu_mem_req
- WriteAddress  in  ADDR_W  CPU word address
- WriteData  in  32  CPU store data
- ReadData  out  32  CPU load data, equal to ram_q
- cam_valid  in  1  camera presents a pixel this cycle
- cam_pixel  in  8  8-bit grey pixel
- cam_ready  out  1  FIFO can accept; equal to (count != FIFO_DEPTH)
- clear_overflow  in  1  synchronous clear of overflow
- overflow  out  1  sticky: a pixel was presented while the FIFO was full
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
- ram_address  out  ADDR_W  RAM address
- ram_data  out  32  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  32  RAM read data

## Operation
- RAM port mux is combinational.
  - When cpu_mem_req=1: ram_address=WriteAddress, ram_data=WriteData, ram_wren=write_enable.
  - Otherwise, when the FIFO is non-empty and reset is high: ram_address=pix_addr, ram_data={24'b0, FIFO head}, ram_wren=1. The head is popped at the edge.
  - Otherwise: ram_wren=0, ram_address=pix_addr, ram_data=0.
- ReadData = ram_q at all times. RAM read latency belongs to the CPU pipeline and is unchanged.
- FIFO push:
  - A pixel is pushed on an edge where cam_valid=1 and count<FIFO_DEPTH. count is the pre-edge value.
  - A same-cycle pop does not make room for a push when the FIFO is full.
  - If cam_valid=1 while full, the pixel is dropped and overflow is set to 1.
- count update: count += push − pop. Pointers wrap modulo FIFO_DEPTH.
- pix_addr:
  - Starts at FRAME_BASE.
  - Increments by 1 on each pop.
  - The pop that writes address FRAME_BASE+FRAME_PIXELS−1 reloads pix_addr to FRAME_BASE and sets frame_done=1 for the following cycle.
- overflow:
  - Set by a dropped pixel; cleared by clear_overflow.
  - If both happen in the same cycle, set wins.
- No state machine beyond FIFO and counter. The CPU path never waits.

## Timing
- Reset (reset=0):
  - count=0, pointers=0, pix_addr=FRAME_BASE, overflow=0, frame_done=0, cam_ready=1.
  - The camera path is gated, so ram_wren follows only the CPU path.
  - No pushes occur while reset=0.
- Reset mid-frame discards FIFO contents and restarts at FRAME_BASE. No frame_done pulse is produced.
- Latency: a pixel pushed at edge N is on the RAM bus in cycle N+1 if the CPU is idle then. With back-to-back CPU accesses it waits indefinitely.
- Throughput: one pixel per cycle when the CPU is idle.
- frame_done is registered. It is high exactly one cycle, the cycle after the final-pixel write edge.
- cam_ready is derived from registered count, with no combinational path from cam_valid.

## Test plan
- Reset, CPU idle, push pixels 0x11,0x22,0x33 on consecutive cycles -> RAM writes 0x11 @0x1000, 0x22 @0x1001, 0x33 @0x1002 on cycles 1–3 after the first push; cam_ready stays 1.
- Hold cpu_mem_req=1 with a store of 0xDEADBEEF @0x40 while pushing 0xAA -> RAM sees only the CPU store. 0xAA is written @0x1000 in the first cycle after cpu_mem_req falls.
- FIFO_DEPTH=8, cpu_mem_req=1 continuously, push 9 pixels -> first 8 accepted, cam_ready=0 after the 8th, 9th dropped, overflow=1. After release, 8 writes @0x1000–0x1007. clear_overflow -> overflow=0.
- FRAME_PIXELS=4, CPU idle, push 6 pixels -> writes @0x1000–0x1003, one frame_done pulse after the 4th write, then pixels 5–6 @0x1000–0x1001.
- Full FIFO, cam_valid=1 in the same cycle as a pop -> pixel dropped, overflow=1, count goes 8→7.
- Assert reset with 3 pixels queued and pix_addr=0x1002 -> count=0, pix_addr=0x1000, no further camera writes, no frame_done. The next pixel is written @0x1000.
